// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: parametrised UART transmitter.
// Accepts a word on a valid/ready handshake and serialises it onto the TX pin
// as start bit, DATA_W data bits (LSB first), optional even/odd parity bit and
// one or two stop bits. Each bit lasts CLKS_PER_BIT clock cycles. A one-cycle
// tx_done pulse marks the return to idle.
module uart_tx_ctrl #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic              two_stop,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    // Bit index needs to reach DATA_W-1.
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Reject illegal configurations at elaboration time.
    generate
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
            $error("uart_tx_ctrl: DATA_W must be in 5..9");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $error("uart_tx_ctrl: CLKS_PER_BIT must be at least 2");
        end
        if (CNT_W < $clog2(CLKS_PER_BIT)) begin : g_bad_cnt_w
            $error("uart_tx_ctrl: CNT_W too narrow for CLKS_PER_BIT");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    // Line value of the parity bit: XOR of the data bits, inverted for odd.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data,
                                        input logic              odd);
        return (^data) ^ odd;
    endfunction

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   shift_q;
    logic                par_en_q;
    logic                par_bit_q;
    logic                two_stop_q;
    logic                tx_q;
    logic                tx_done_q;
    logic                bit_end;

    // Last cycle of the current serial bit.
    assign bit_end  = (cnt_q == CNT_LAST);

    // Handshake and status outputs follow the state register directly.
    assign tx_ready = (state_q == S_IDLE);
    assign busy     = ~tx_ready;
    assign tx       = tx_q;
    assign tx_done  = tx_done_q;

    // Frame sequencer: state, baud counter, shift register and registered line.
    // The line register is loaded with the value of the state being entered,
    // so the start bit appears on the same edge that accepts the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (tx_valid) begin
                        shift_q    <= tx_data;
                        par_en_q   <= par_en;
                        par_bit_q  <= parity_bit(tx_data, par_odd);
                        two_stop_q <= two_stop;
                        tx_q       <= 1'b0;
                        state_q    <= S_START;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            if (par_en_q) begin
                                tx_q    <= par_bit_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP1;
                            end
                        end else begin
                            idx_q   <= idx_q + IDX_ONE;
                            shift_q <= {1'b0, shift_q[DATA_W-1:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_STOP1: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        tx_q  <= 1'b1;
                        if (two_stop_q) begin
                            state_q <= S_STOP2;
                        end else begin
                            state_q   <= S_IDLE;
                            tx_done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_STOP2: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        tx_q      <= 1'b1;
                        state_q   <= S_IDLE;
                        tx_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl with CLKS_PER_BIT = 4.
// dut8 uses DATA_W = 8, dut5 uses DATA_W = 5; both share clock and reset.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data8;
    logic [4:0] data5;
    logic       valid8, valid5;
    logic       par_en, par_odd, two_stop;
    logic       ready8, tx8, busy8, done8;
    logic       ready5, tx5, busy5, done5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_W(8), .CLKS_PER_BIT(4)) dut8 (
        .clk(clk), .rst(rst), .tx_data(data8), .tx_valid(valid8),
        .tx_ready(ready8), .par_en(par_en), .par_odd(par_odd),
        .two_stop(two_stop), .tx(tx8), .busy(busy8), .tx_done(done8)
    );

    uart_tx_ctrl #(.DATA_W(5), .CLKS_PER_BIT(4)) dut5 (
        .clk(clk), .rst(rst), .tx_data(data5), .tx_valid(valid5),
        .tx_ready(ready5), .par_en(par_en), .par_odd(par_odd),
        .two_stop(two_stop), .tx(tx5), .busy(busy5), .tx_done(done5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line value k cycles after the accept edge (4 cycles per bit).
    function automatic logic frame_bit(input logic [8:0] data, input int w,
                                       input logic pe, input logic par, input int k);
        int idx;
        idx = k / 4;
        if (idx == 0) return 1'b0;
        if (idx <= w) return data[idx-1];
        if (pe && idx == w + 1) return par;
        return 1'b1;
    endfunction

    // Offer a word at a falling edge; returns just after the accepting edge.
    task automatic start_frame(input logic [8:0] data, input bit use5,
                               input logic pe, input logic po, input logic ts);
        @(negedge clk);
        chk("ready_before_accept", use5 ? ready5 : ready8, 1'b1);
        par_en   = pe;
        par_odd  = po;
        two_stop = ts;
        if (use5) begin
            data5  = data[4:0];
            valid5 = 1'b1;
        end else begin
            data8  = data[7:0];
            valid8 = 1'b1;
        end
        @(posedge clk);
    endtask

    // Check every cycle of a frame, then the done cycle. Optionally changes
    // data8 at two given cycles to prove the frame ignores late input changes.
    task automatic watch_frame(input logic [8:0] data, input int w, input logic pe,
                               input logic par, input logic ts, input bit use5,
                               input string tag, input int chg_a, input logic [7:0] val_a,
                               input int chg_b, input logic [7:0] val_b);
        int n;
        n = (2 + w + (pe ? 1 : 0) + (ts ? 1 : 0)) * 4;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk({tag, "_tx"},    use5 ? tx5 : tx8,       frame_bit(data, w, pe, par, k));
            chk({tag, "_ready"}, use5 ? ready5 : ready8, 1'b0);
            chk({tag, "_busy"},  use5 ? busy5 : busy8,   1'b1);
            chk({tag, "_done"},  use5 ? done5 : done8,   1'b0);
            if (k == chg_a) data8 = val_a;
            if (k == chg_b) data8 = val_b;
        end
        @(negedge clk);
        chk({tag, "_end_done"},  use5 ? done5 : done8,   1'b1);
        chk({tag, "_end_ready"}, use5 ? ready5 : ready8, 1'b1);
        chk({tag, "_end_busy"},  use5 ? busy5 : busy8,   1'b0);
        chk({tag, "_end_tx"},    use5 ? tx5 : tx8,       1'b1);
    endtask

    initial begin
        rst = 1'b1; valid8 = 1'b0; valid5 = 1'b0;
        data8 = 8'h00; data5 = 5'h00;
        par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx8", tx8, 1'b1);       chk("rst_ready8", ready8, 1'b1);
        chk("rst_busy8", busy8, 1'b0);   chk("rst_done8", done8, 1'b0);
        chk("rst_tx5", tx5, 1'b1);       chk("rst_done5", done5, 1'b0);
        rst = 1'b0;

        // 8N1, 0xA5
        start_frame(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 valid8 = 1'b0;
        watch_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0, "8n1_a5", -1, 8'h00, -1, 8'h00);
        @(negedge clk);
        chk("8n1_a5_done_pulse", done8, 1'b0);

        // 8E1 0x07 -> parity 1
        start_frame(9'h007, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 valid8 = 1'b0;
        watch_frame(9'h007, 8, 1'b1, 1'b1, 1'b0, 1'b0, "8e1_07", -1, 8'h00, -1, 8'h00);
        @(negedge clk);
        chk("8e1_07_done_pulse", done8, 1'b0);

        // 8O1 0x07 -> parity 0
        start_frame(9'h007, 1'b0, 1'b1, 1'b1, 1'b0);
        #1 valid8 = 1'b0;
        watch_frame(9'h007, 8, 1'b1, 1'b0, 1'b0, 1'b0, "8o1_07", -1, 8'h00, -1, 8'h00);
        @(negedge clk);

        // 8E1 0x00 -> parity 0
        start_frame(9'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 valid8 = 1'b0;
        watch_frame(9'h000, 8, 1'b1, 1'b0, 1'b0, 1'b0, "8e1_00", -1, 8'h00, -1, 8'h00);
        @(negedge clk);

        // 8N2 0xFF -> two stop bits, 44-cycle frame
        start_frame(9'h0FF, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 valid8 = 1'b0;
        watch_frame(9'h0FF, 8, 1'b0, 1'b0, 1'b1, 1'b0, "8n2_ff", -1, 8'h00, -1, 8'h00);
        @(negedge clk);
        chk("8n2_ff_done_pulse", done8, 1'b0);

        // Back-to-back with tx_valid held high; data changes while busy
        start_frame(9'h011, 1'b0, 1'b0, 1'b0, 1'b0);
        watch_frame(9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_first", 8, 8'h22, 20, 8'h33);
        @(posedge clk);
        watch_frame(9'h033, 8, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_second", 12, 8'h44, -1, 8'h00);
        valid8 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("b2b_idle_tx", tx8, 1'b1);
            chk("b2b_idle_ready", ready8, 1'b1);
            chk("b2b_idle_done", done8, 1'b0);
        end

        // Reset during DATA bit 3 (frame cycles 16..19)
        start_frame(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 valid8 = 1'b0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk("abort_pre_tx", tx8, frame_bit(9'h0A5, 8, 1'b0, 1'b0, k));
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_tx", tx8, 1'b1);
        chk("abort_ready", ready8, 1'b1);
        chk("abort_busy", busy8, 1'b0);
        chk("abort_done", done8, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_after_done", done8, 1'b0);
            chk("abort_after_tx", tx8, 1'b1);
        end
        start_frame(9'h03C, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 valid8 = 1'b0;
        watch_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, "post_abort", -1, 8'h00, -1, 8'h00);
        @(negedge clk);

        // DATA_W=5, odd parity, 0x1F -> parity 0, 32-cycle frame
        start_frame(9'h01F, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 valid5 = 1'b0;
        watch_frame(9'h01F, 5, 1'b1, 1'b0, 1'b0, 1'b1, "w5_o1_1f", -1, 8'h00, -1, 8'h00);
        @(negedge clk);
        chk("w5_done_pulse", done5, 1'b0);
        chk("w5_dut8_quiet", busy8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Parametrised UART transmitter: frame sequencer, internal baud counter, shift register and parity generator in one block.
- Supersedes the fixed 8-bit TX control FSM.
- Adds configurable data width, even/odd/no parity, 1 or 2 stop bits, a valid/ready input handshake and a done pulse.
- Sits between the SoC UART register interface (bus side) and the TX pin.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal minimum 2.
- CNT_W, $clog2(CLKS_PER_BIT), width of the baud counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_W  parallel data; sampled on accept.
- tx_valid  input  1  data offered.
- tx_ready  output  1  block can accept; high only in IDLE.
- par_en  input  1  parity bit enable; sampled on accept.
- par_odd  input  1  1 = odd parity, 0 = even; sampled on accept.
- two_stop  input  1  1 = two stop bits; sampled on accept.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  frame in progress (= !tx_ready).
- tx_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - state = IDLE; tx = 1; tx_done = 0; baud counter, bit index and shift register = 0.
  - Reset asserted mid-frame aborts the frame: tx = 1 from the next edge, no tx_done pulse.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Accept: tx_valid && tx_ready at edge E.
  - Latch tx_data, par_en, par_odd, two_stop.
  - state -> START; tx <= 0 at E (zero cycles latency to line).
  - Input changes after E have no effect on the current frame.
- Bit timing:
  - Every non-IDLE state holds tx constant for exactly CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1, clears on each state/bit change.
  - Transitions occur on the edge where counter == CLKS_PER_BIT-1.
- Transitions and line values:
  - START -> DATA.
  - DATA sends LSB first; bit index 0..DATA_W-1; after bit DATA_W-1, -> PARITY if par_en, else -> STOP1.
  - PARITY: tx = ^data XOR par_odd (even: XOR of the data bits; odd: its inverse) -> STOP1.
  - STOP1: tx = 1 -> STOP2 if two_stop, else -> IDLE.
  - STOP2: tx = 1 -> IDLE.
- Frame length: (1 + DATA_W + par_en + 1 + two_stop) * CLKS_PER_BIT cycles, measured from E.
- tx_done: high for exactly one cycle, registered, on the edge entering IDLE from the last stop bit.
- tx_ready: combinational from state; low from edge E until the return to IDLE.
- tx_valid while busy: ignored; the data is not queued and the frame in progress is undisturbed.
- Back-to-back frames:
  - tx_valid held high is accepted on the first IDLE cycle after tx_done.
  - Result: exactly one idle cycle (tx = 1) between frames, in addition to the stop bits.
- DATA_W = 9 with par_en = 1 gives a legal 12- or 13-bit frame; no width truncation anywhere.
- Out-of-range parameters are a compile-time error (generate-time $error).

Test Plan:
- CLKS_PER_BIT=4, 8N1, data 0xA5 -> tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles; tx_done pulses at cycle 40 after accept; tx_ready low for cycles 0..39.
- 8E1, data 0x07 -> parity bit 1; 8O1, data 0x07 -> parity 0; 8E1, data 0x00 -> parity 0; frame length 44 cycles.
- 8N2, data 0xFF -> two stop bits of 4 cycles each; tx_done at cycle 44; busy high throughout.
- tx_valid held high with 0x11 then 0x22; tx_data changed to 0x33 mid-frame -> first frame carries 0x11 unchanged; second frame carries the value present at re-accept; exactly 1 idle cycle between frames; no third accept while busy.
- rst pulsed during DATA bit 3 -> next cycle tx = 1, tx_ready = 1, no tx_done; a new accept afterwards sends a clean full frame.
- DATA_W=5, par_en=1, par_odd=1, data 0x1F -> 5 data bits, parity 0, 8-bit frame of 32 cycles.
